aes_key_sched: RTL and testbench
================================

# aes_key_sched

Byte-serial AES-128 key schedule that sits directly downstream of the serial-to-parallel key loader. When the loader signals `ready`, this block captures its 128-bit key into the round-key register. Each `next` request then generates the following round key using a single shared S-box, one byte per cycle. Round keys are presented in parallel to the round datapath. Area is favoured over throughput: there is one S-box, and no key storage beyond the current round key.

## Interface
Parameters:
- `ROUNDS`, default 10: last round index (AES-128).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `key`, in, 128: cipher key from the loader. Byte 0 (the first received byte) is `key[127:120]`.
- `load`, in, 1: one-cycle strobe, driven by the loader's `ready`. Captures `key`.
- `next`, in, 1: request for the next round key. It is a level, sampled each cycle.
- `rk`, out, 128: current round key. Same byte order as `key`.
- `round`, out, 4: index of the key held in `rk` (0..ROUNDS).
- `valid`, out, 1: `rk` holds a complete round key and the block is idle.
- `busy`, out, 1: round-key computation in progress.
- `last`, out, 1: `valid` && `round`==ROUNDS.

## Operation
- Internal state:
  - words w0..w3 = `rk[127:96]`..`rk[31:0]`;
  - rcon, 8-bit;
  - temp word, 32-bit;
  - byte counter, 2-bit;
  - loaded flag.
- FSM states:
  - IDLE:
    - `load`=1: `rk`<=`key`, `round`<=0, rcon<=8'h01, loaded<=1. Stay in IDLE.
    - else `next`=1 && loaded && `round`<ROUNDS: temp<=RotWord(w3) = {w3[23:0], w3[31:24]}, counter<=0. Go to SUB.
    - otherwise `next` is ignored.
  - SUB, 4 cycles: the counter selects one byte of temp; that byte <= Sbox(byte); counter++. After counter==3 is processed, go to MIX.
  - MIX, 1 cycle:
    - w0'=w0^temp^{rcon,24'h0};
    - w1'=w1^w0';
    - w2'=w2^w1';
    - w3'=w3^w2';
    - `rk`<={w0',w1',w2',w3'}, `round`++, rcon<=xtime(rcon).
    - Go to IDLE.
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- The S-box is the standard FIPS-197 forward table, combinational. There is one instance.
- Boundaries:
  - `load` in SUB or MIX aborts the computation. The key is captured exactly as in IDLE, the state returns to IDLE, and the partial temp is discarded.
  - `load` and `next` in the same IDLE cycle: `load` wins and `next` is dropped.
  - `next` while `round`==ROUNDS: ignored. The block stays at `last`.
  - `next` before any `load` since reset: ignored.
  - `next` held high: a new computation starts on each IDLE cycle until `round`==ROUNDS. The result is one key every 6 cycles.
  - `key` changing while not loading has no effect.

## Timing
- Reset values: `rk`=0, `round`=0, `valid`=0, `busy`=0, `last`=0. Also state=IDLE, rcon=8'h01, loaded=0.
- `load` sampled at edge E: `rk`, `round`, and `valid`=1 are visible after E. Load latency is 1 cycle.
- `next` accepted at edge E0:
  - `busy`=1 and `valid`=0 after E0;
  - S-box bytes are processed at E1..E4;
  - MIX occurs at E5: the new `rk` and `round`+1 are visible after E5, with `busy`=0 and `valid`=1.
  - Latency is 5 cycles from the accepting edge.
- `busy` and `valid` are never high together. `valid`=loaded && state==IDLE.
- Outputs are registered only. There are no combinational paths from inputs to outputs.
- Reset mid-computation returns all outputs to their reset values on that edge.

## Test plan
- **FIPS-197 A.1 key.** Load `key`=128'h2b7e151628aed2a6abf7158809cf4f3c, then pulse `next`.
  - Expected: after 5 cycles `rk`=128'ha0fafe1788542cb123a339392a6c7605, `round`=1.
  - Continue to round 10. Expected: `rk`=128'hd014f9a8c9ee2589e13f0cc8b6630ca6, `last`=1.
- **Second key, held next.** Load `key`=128'h000102030405060708090a0b0c0d0e0f and hold `next` high.
  - Expected: round keys appear every 6 cycles. Round 10 `rk`=128'h13111d7fe3944a17f307a78b4d2b30c5.
  - Expected: further `next` leaves `rk` and `round` unchanged.
- **Loader chain.** Drive the upstream loader with bytes 00,11,…,ff and tie its `ready` to `load`.
  - Expected: `rk`=128'h00112233445566778899aabbccddeeff, `round`=0, `valid`=1 one cycle after `ready`.
- **Abort and collision.** Assert `load` during SUB counter=2.
  - Expected: the new key is captured, `round`=0, and there is no MIX update.
  - Assert `load` and `next` together in IDLE. Expected: only the load takes effect, with `busy`=0.
- **Reset mid-computation.** Apply `rst` during MIX-1. Expected: all outputs become 0.
  - Then apply `next` with no load. Expected: ignored, `busy` stays 0.
- **Rcon wrap.** Check the round 9 to round 10 transitions with key A.1.
  - Expected: the rcon used is 1b, then 36, so xtime wraps correctly.

Source files
------------

// File: rtl/aes_key_sched.sv
// aes_key_sched: byte-serial AES-128 key schedule.
// Holds the current round key and, on each accepted request, derives the next
// one with a single shared forward S-box, one byte per cycle, followed by a
// one-cycle word-mixing step. A new key from the loader can be captured at any
// time and aborts any computation in flight.
module aes_key_sched #(
    parameter int ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         load,
    input  logic         next,
    output logic [127:0] rk,
    output logic [3:0]   round,
    output logic         valid,
    output logic         busy,
    output logic         last
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    // FIPS-197 forward S-box, row-major: entry 0 occupies the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        MIX
    } state_t;

    state_t      state;
    logic [7:0]  rcon;
    logic [31:0] temp;
    logic [1:0]  cnt;
    logic        loaded;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  sub_in;
    logic [7:0]  sub_out;

    // Byte x lives at bit positions {~x, 3'b111} down to {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b111};
        return SBOX_TBL[base -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    // Byte of the rotated word fed to the shared S-box on this SUB cycle.
    always_comb begin
        sub_in = temp[31:24];
        case (cnt)
            2'd0: sub_in = temp[31:24];
            2'd1: sub_in = temp[23:16];
            2'd2: sub_in = temp[15:8];
            2'd3: sub_in = temp[7:0];
            default: sub_in = temp[31:24];
        endcase
    end

    assign sub_out = sbox(sub_in);

    // Word chaining for the next round key; consumed only in MIX.
    always_comb begin
        n0 = w0 ^ temp ^ {rcon, 24'h0};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    // Control FSM and round-key register; load takes priority in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rk     <= '0;
            round  <= '0;
            rcon   <= 8'h01;
            temp   <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            last   <= 1'b0;
        end else if (load) begin
            state  <= IDLE;
            rk     <= key;
            round  <= '0;
            rcon   <= 8'h01;
            loaded <= 1'b1;
            valid  <= 1'b1;
            busy   <= 1'b0;
            last   <= (LAST_RND == 4'd0);
        end else begin
            case (state)
                IDLE: begin
                    if (next && loaded && (round < LAST_RND)) begin
                        temp  <= {w3[23:0], w3[31:24]};
                        cnt   <= 2'd0;
                        state <= SUB;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                        last  <= 1'b0;
                    end
                end
                SUB: begin
                    case (cnt)
                        2'd0: temp[31:24] <= sub_out;
                        2'd1: temp[23:16] <= sub_out;
                        2'd2: temp[15:8]  <= sub_out;
                        2'd3: temp[7:0]   <= sub_out;
                        default: temp[31:24] <= sub_out;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= MIX;
                    end
                end
                MIX: begin
                    rk    <= {n0, n1, n2, n3};
                    round <= round + 4'd1;
                    rcon  <= xtime(rcon);
                    state <= IDLE;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    last  <= ((round + 4'd1) == LAST_RND);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= loaded;
                    last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Testbench for aes_key_sched: a cycle-level reference model built from the
// AES key-expansion rules (S-box derived from the GF(2^8) inverse and affine
// map), compared against the DUT every cycle, plus directed FIPS-197 vectors.
module tb_aes_key_sched;

    localparam int ROUNDS = 10;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_LD  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         load;
    logic         next;
    logic [127:0] rk;
    logic [3:0]   round;
    logic         valid;
    logic         busy;
    logic         last;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0]   sb [256];
    logic [7:0]   rcon_tab [10];

    logic [127:0] m_rk;
    int           m_round;
    logic         m_loaded;
    int           m_cd;

    always #5 clk = ~clk;

    aes_key_sched #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .load  (load),
        .next  (next),
        .rk    (rk),
        .round (round),
        .valid (valid),
        .busy  (busy),
        .last  (last)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Reference model: one request costs 5 edges, load and reset override.
    always @(posedge clk) begin
        if (rst) begin
            m_rk     <= '0;
            m_round  <= 0;
            m_loaded <= 1'b0;
            m_cd     <= 0;
        end else if (load) begin
            m_rk     <= key;
            m_round  <= 0;
            m_loaded <= 1'b1;
            m_cd     <= 0;
        end else if (m_cd > 1) begin
            m_cd <= m_cd - 1;
        end else if (m_cd == 1) begin
            m_cd    <= 0;
            m_rk    <= expand(m_rk, rcon_tab[m_round]);
            m_round <= m_round + 1;
        end else if (next && m_loaded && m_round < ROUNDS) begin
            m_cd <= 5;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rk", rk, m_rk);
            check("cyc_round", 128'(round), 128'(m_round));
            check("cyc_valid", 128'(valid), 128'(m_loaded && m_cd == 0));
            check("cyc_busy", 128'(busy), 128'(m_cd != 0));
            check("cyc_last", 128'(last), 128'(m_loaded && m_cd == 0 && m_round == ROUNDS));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic one_round();
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int n;
        logic [127:0] sh;
        rst  = 1'b1;
        load = 1'b0;
        next = 1'b0;
        key  = '0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sb[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        check("sbox_00", 128'(sb[8'h00]), 128'h63);
        check("sbox_53", 128'(sb[8'h53]), 128'hed);
        check("sbox_ff", 128'(sb[8'hff]), 128'h16);

        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_rk", rk, 128'h0);
        check("rst_valid", 128'(valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);

        // next before any load is ignored
        next = 1'b1;
        repeat (3) tick();
        next = 1'b0;
        check("noload_busy", 128'(busy), 128'h0);

        // FIPS-197 A.1 key
        key  = KEY_A1;
        load = 1'b1;
        tick();
        load = 1'b0;
        key  = '0;
        check("a1_load_rk", rk, KEY_A1);
        one_round();
        check("a1_r1_rk", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_r1_round", 128'(round), 128'd1);
        for (int r = 2; r <= ROUNDS; r++) begin
            one_round();
            if (r == 9) check("a1_r9_rk", rk, 128'hac7766f319fadc2128d12941575c006e);
        end
        check("a1_r10_rk", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a1_r10_last", 128'(last), 128'h1);

        // Second key, next held high
        key  = KEY_2;
        load = 1'b1;
        tick();
        load = 1'b0;
        next = 1'b1;
        n = 0;
        while (!last && n < 100) begin
            tick();
            n++;
        end
        check("k2_cycles", 128'(n), 128'd60);
        check("k2_r10_rk", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        repeat (10) tick();
        check("k2_hold_rk", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("k2_hold_round", 128'(round), 128'd10);
        next = 1'b0;

        // Loader chain: shift bytes 00,11,...,ff then strobe ready into load
        sh = '0;
        for (int i = 0; i < 16; i++) begin
            sh = {sh[119:0], 8'(i * 17)};
            tick();
        end
        key  = sh;
        load = 1'b1;
        tick();
        load = 1'b0;
        key  = 128'hdeadbeef;
        check("ld_rk", rk, KEY_LD);
        check("ld_round", 128'(round), 128'd0);
        check("ld_valid", 128'(valid), 128'h1);

        // Abort: load sampled while the SUB counter is 2
        next = 1'b1;
        tick();
        next = 1'b0;
        tick();
        tick();
        key  = KEY_A1;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("abort_rk", rk, KEY_A1);
        check("abort_busy", 128'(busy), 128'h0);
        repeat (5) tick();
        check("abort_nomix_rk", rk, KEY_A1);
        check("abort_nomix_round", 128'(round), 128'd0);

        // load and next together in IDLE
        key  = KEY_2;
        load = 1'b1;
        next = 1'b1;
        tick();
        load = 1'b0;
        next = 1'b0;
        check("coll_busy", 128'(busy), 128'h0);
        check("coll_rk", rk, KEY_2);
        repeat (6) tick();
        check("coll_round", 128'(round), 128'd0);

        // Reset on the edge just before MIX
        next = 1'b1;
        tick();
        next = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_rk", rk, 128'h0);
        check("rstmid_valid", 128'(valid), 128'h0);
        check("rstmid_round", 128'(round), 128'h0);
        next = 1'b1;
        repeat (8) tick();
        next = 1'b0;
        check("rstmid_next_busy", 128'(busy), 128'h0);
        check("rstmid_next_rk", rk, 128'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
